// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage.
// No logic; enum codes match the execute-stage ALU encoding.
// Imported by the decoder and the issue register.
package alu_pkg;

  localparam int XLEN_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SLL  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SRA  = 4'd6,
    ALU_OR   = 4'd7,
    ALU_AND  = 4'd8,
    ALU_SUB  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  // Operand A source
  typedef enum logic [1:0] {
    A_ZERO = 2'd0,
    A_RS1  = 2'd1,
    A_PC   = 2'd2
  } a_sel_e;

  // Operand B source; shift variants carry only the 5-bit amount
  typedef enum logic [2:0] {
    B_ZERO      = 3'd0,
    B_RS2       = 3'd1,
    B_RS2_SHAMT = 3'd2,
    B_IMM_I     = 3'd3,
    B_SHAMT_I   = 3'd4,
    B_IMM_U     = 3'd5
  } b_sel_e;

  // Registered issue slot presented to the ALU
  typedef struct packed {
    logic [XLEN_W-1:0] a;
    logic [XLEN_W-1:0] b;
    alu_op_e           alu_op;
    logic [4:0]        rd;
    logic              rd_we;
    logic              illegal;
    logic [XLEN_W-1:0] pc;
  } issue_t;

  // funct3 to ALU op; alt selects SUB/SRA where that alternative exists
  function automatic alu_op_e funct3_to_op(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between decode, register file, issue stage and ALU.
// Latency: none (wires only).
// Backpressure: out_ready from the ALU side, in_ready back to decode.
interface alu_issue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [3:0]      out_alu_op;
  logic [4:0]      out_rd;
  logic            out_rd_we;
  logic            out_illegal;
  logic [XLEN-1:0] out_pc;

  // Environment side: decode/register file upstream, ALU downstream
  modport master (
    output in_valid, in_instr, in_pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_alu_op, out_rd,
           out_rd_we, out_illegal, out_pc
  );

  // Issue stage side
  modport slave (
    input  in_valid, in_instr, in_pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_alu_op, out_rd,
           out_rd_we, out_illegal, out_pc
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32I OP/OP-IMM/LUI/AUIPC decode into ALU op and operand selects.
// Latency: 0 cycles.
// Backpressure: none; pure function of the instruction word.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_e     alu_op,
  output a_sel_e      a_sel,
  output b_sel_e      b_sel,
  output logic        rd_we,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       is_shift;
  logic       unused_fields;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rd       = instr[11:7];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  // Register and immediate fields are consumed by the operand muxes instead
  assign unused_fields = ^instr[24:15];

  // Decode opcode/funct fields; illegal slots collapse to ADD 0+0 with no writeback
  always_comb begin
    alu_op  = ALU_ADD;
    a_sel   = A_ZERO;
    b_sel   = B_ZERO;
    illegal = 1'b0;
    rd_we   = 1'b0;

    case (opcode)
      OPC_OP: begin
        a_sel = A_RS1;
        b_sel = is_shift ? B_RS2_SHAMT : B_RS2;
        if (funct7 == 7'b0000000) begin
          alu_op = funct3_to_op(funct3, 1'b0);
        end else if (funct7 == FUNCT7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          alu_op = funct3_to_op(funct3, 1'b1);
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        a_sel = A_RS1;
        if (is_shift) begin
          b_sel = B_SHAMT_I;
          if (funct7 == 7'b0000000) begin
            alu_op = funct3_to_op(funct3, 1'b0);
          end else if (funct7 == FUNCT7_ALT && funct3 == 3'b101) begin
            alu_op = ALU_SRA;
          end else begin
            illegal = 1'b1;
          end
        end else begin
          // Immediate forms never subtract, whatever instr[30] holds
          b_sel  = B_IMM_I;
          alu_op = funct3_to_op(funct3, 1'b0);
        end
      end
      OPC_LUI: begin
        a_sel = A_ZERO;
        b_sel = B_IMM_U;
      end
      OPC_AUIPC: begin
        a_sel = A_PC;
        b_sel = B_IMM_U;
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      alu_op = ALU_ADD;
      a_sel  = A_ZERO;
      b_sel  = B_ZERO;
    end
    rd_we = !illegal && (rd != 5'd0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue register feeding the ALU; optional writeback forwarding under ALU_FWD_EN.
// Latency: 1 cycle from input handshake to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; held slot is bit-stable; flush kills held and incoming.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
`ifdef ALU_FWD_EN
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
`endif
  alu_issue_if.slave      bus
);

  if (XLEN != 32) begin : g_xlen_check
    $error("alu_issue_stage: only XLEN=32 is supported");
  end

  alu_op_e         dec_op;
  a_sel_e          dec_a_sel;
  b_sel_e          dec_b_sel;
  logic            dec_rd_we;
  logic            dec_illegal;

  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic [XLEN-1:0] rs1_eff;
  logic [XLEN-1:0] rs2_eff;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  issue_t          nxt;
  issue_t          cur;
  logic            valid_q;
  logic            load;

  alu_op_decode u_decode (
    .instr   (bus.in_instr),
    .alu_op  (dec_op),
    .a_sel   (dec_a_sel),
    .b_sel   (dec_b_sel),
    .rd_we   (dec_rd_we),
    .illegal (dec_illegal)
  );

  assign rs1_idx = bus.in_instr[19:15];
  assign rs2_idx = bus.in_instr[24:20];
  assign imm_i   = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign imm_u   = {bus.in_instr[31:12], 12'b0};

`ifdef ALU_FWD_EN
  // Same-cycle writeback overrides the stale register-file read; x0 is never forwarded
  always_comb begin
    rs1_eff = bus.rs1_data;
    rs2_eff = bus.rs2_data;
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs1_idx) rs1_eff = wb_data;
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs2_idx) rs2_eff = wb_data;
  end
`else
  logic unused_idx;
  assign unused_idx = ^{rs1_idx, rs2_idx};
  assign rs1_eff    = bus.rs1_data;
  assign rs2_eff    = bus.rs2_data;
`endif

  // Operand selection; register shifts keep only the low five bits of rs2
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (dec_a_sel)
      A_RS1:   op_a = rs1_eff;
      A_PC:    op_a = bus.in_pc;
      default: op_a = '0;
    endcase
    case (dec_b_sel)
      B_RS2:       op_b = rs2_eff;
      B_RS2_SHAMT: op_b = {{(XLEN-5){1'b0}}, rs2_eff[4:0]};
      B_IMM_I:     op_b = imm_i;
      B_SHAMT_I:   op_b = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
      B_IMM_U:     op_b = imm_u;
      default:     op_b = '0;
    endcase
  end

  // Assemble the slot to be registered
  always_comb begin
    nxt         = '0;
    nxt.a       = op_a;
    nxt.b       = op_b;
    nxt.alu_op  = dec_op;
    nxt.rd      = bus.in_instr[11:7];
    nxt.rd_we   = dec_rd_we;
    nxt.illegal = dec_illegal;
    nxt.pc      = bus.in_pc;
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  // Flush wins over a same-cycle load
  assign load         = bus.in_valid && bus.in_ready && !flush;

  // Valid tracking: flush clears, load sets, consumption without refill clears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Data register only moves on a load, so a stalled slot stays bit-stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= '0;
    end else if (load) begin
      cur <= nxt;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_a       = cur.a;
  assign bus.out_b       = cur.b;
  assign bus.out_alu_op  = cur.alu_op;
  assign bus.out_rd      = cur.rd;
  assign bus.out_rd_we   = cur.rd_we;
  assign bus.out_illegal = cur.illegal;
  assign bus.out_pc      = cur.pc;

endmodule
